// File: rtl/dccm_arb_pkg.sv
// Shared types and constants for the DCCM port arbiter.
package dccm_arb_pkg;
    localparam int STALL_CNT_W = 8;

    typedef enum logic [1:0] {ARB_RUN, ARB_HALTING, ARB_HALTED} arb_state_t;
    typedef enum logic {OWN_LSU, OWN_DMA} arb_owner_t;
endpackage

// File: rtl/dccm_port_arb_if.sv
// Request, memory-port and response bundle between the requesters, the arbiter and the wrapper.
interface dccm_port_arb_if #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39
);
    import dccm_arb_pkg::*;

    logic                        lsu_req_valid;
    logic                        lsu_req_write;
    logic [DCCM_BITS-1:0]        lsu_req_addr;
    logic [DCCM_FDATA_WIDTH-1:0] lsu_req_wdata;
    logic                        lsu_req_ready;
    logic                        dma_req_valid;
    logic                        dma_req_write;
    logic [DCCM_BITS-1:0]        dma_req_addr;
    logic [DCCM_FDATA_WIDTH-1:0] dma_req_wdata;
    logic                        dma_req_ready;
    logic                        arb_halt_req;
    logic                        arb_halt_ack;
    logic                        dccm_wren;
    logic                        dccm_rden;
    logic [DCCM_BITS-1:0]        dccm_wr_addr_lo;
    logic [DCCM_BITS-1:0]        dccm_wr_addr_hi;
    logic [DCCM_BITS-1:0]        dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0]        dccm_rd_addr_hi;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi;
    logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo;
    logic                        lsu_rsp_valid;
    logic                        dma_rsp_valid;
    logic [DCCM_FDATA_WIDTH-1:0] rsp_data;
    logic [STALL_CNT_W-1:0]      dma_stall_cnt;

    modport slave (
        input  lsu_req_valid, lsu_req_write, lsu_req_addr, lsu_req_wdata,
        input  dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata,
        input  arb_halt_req, dccm_rd_data_lo,
        output lsu_req_ready, dma_req_ready, arb_halt_ack,
        output dccm_wren, dccm_rden, dccm_wr_addr_lo, dccm_wr_addr_hi,
        output dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi,
        output lsu_rsp_valid, dma_rsp_valid, rsp_data, dma_stall_cnt
    );

    modport master (
        output lsu_req_valid, lsu_req_write, lsu_req_addr, lsu_req_wdata,
        output dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata,
        output arb_halt_req, dccm_rd_data_lo,
        input  lsu_req_ready, dma_req_ready, arb_halt_ack,
        input  dccm_wren, dccm_rden, dccm_wr_addr_lo, dccm_wr_addr_hi,
        input  dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi,
        input  lsu_rsp_valid, dma_rsp_valid, rsp_data, dma_stall_cnt
    );
endinterface

// File: rtl/dccm_arb_stall_ctr.sv
// Saturating count of cycles DMA lost arbitration; force_dma once the limit is reached.
module dccm_arb_stall_ctr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_force
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt < i_limit)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_force = (r_cnt == i_limit);
endmodule

// File: rtl/dccm_port_arb.sv
// Shares the single DCCM port between LSU and DMA with same-cycle grant,
// one-cycle read response routing and a halt/quiesce handshake.
module dccm_port_arb
    import dccm_arb_pkg::*;
#(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int DCCM_BYTE_WIDTH  = 4,
    parameter int DMA_MAX_STALL    = 8
) (
    input  logic           clk,
    input  logic           rst_l,
    dccm_port_arb_if.slave bus
);
    localparam logic [DCCM_BITS-1:0] ALIGN_MASK = DCCM_BITS'(DCCM_BYTE_WIDTH - 1);

    arb_state_t                  r_state;
    arb_state_t                  w_state_next;
    logic                        r_rsp_pending;
    arb_owner_t                  r_rsp_owner;
    logic                        w_halt_ack;
    logic [STALL_CNT_W-1:0]      w_stall_cnt;
    logic                        w_force_dma;
    logic                        w_grant_ok;
    logic                        w_dma_win;
    logic                        w_lsu_acc;
    logic                        w_dma_acc;
    logic                        w_acc_write;
    logic                        w_acc_read;
    logic [DCCM_BITS-1:0]        w_sel_addr;
    logic [DCCM_FDATA_WIDTH-1:0] w_sel_wdata;

    // Grants are also gated by rst_l so nothing is issued while reset is held.
    assign w_grant_ok  = rst_l && (r_state == ARB_RUN) && !bus.arb_halt_req;
    assign w_dma_win   = bus.dma_req_valid && (w_force_dma || !bus.lsu_req_valid);
    assign w_dma_acc   = w_grant_ok && w_dma_win;
    assign w_lsu_acc   = w_grant_ok && bus.lsu_req_valid && !w_dma_win;
    assign w_sel_addr  = w_dma_acc ? bus.dma_req_addr  : bus.lsu_req_addr;
    assign w_sel_wdata = w_dma_acc ? bus.dma_req_wdata : bus.lsu_req_wdata;
    assign w_acc_write = (w_lsu_acc && bus.lsu_req_write) || (w_dma_acc && bus.dma_req_write);
    assign w_acc_read  = (w_lsu_acc && !bus.lsu_req_write) || (w_dma_acc && !bus.dma_req_write);

    assign bus.lsu_req_ready   = w_lsu_acc;
    assign bus.dma_req_ready   = w_dma_acc;
    assign bus.dccm_wren       = w_acc_write;
    assign bus.dccm_rden       = w_acc_read;
    assign bus.dccm_wr_addr_lo = w_acc_write ? w_sel_addr  : '0;
    assign bus.dccm_wr_addr_hi = bus.dccm_wr_addr_lo;
    assign bus.dccm_rd_addr_lo = w_acc_read  ? w_sel_addr  : '0;
    assign bus.dccm_rd_addr_hi = bus.dccm_rd_addr_lo;
    assign bus.dccm_wr_data_lo = w_acc_write ? w_sel_wdata : '0;
    assign bus.dccm_wr_data_hi = bus.dccm_wr_data_lo;

    assign bus.lsu_rsp_valid = r_rsp_pending && (r_rsp_owner == OWN_LSU);
    assign bus.dma_rsp_valid = r_rsp_pending && (r_rsp_owner == OWN_DMA);
    assign bus.rsp_data      = r_rsp_pending ? bus.dccm_rd_data_lo : '0;
    assign bus.arb_halt_ack  = w_halt_ack;
    assign bus.dma_stall_cnt = w_stall_cnt;

    dccm_arb_stall_ctr #(
        .CNT_W (STALL_CNT_W)
    ) u_stall_ctr (
        .clk     (clk),
        .rst_l   (rst_l),
        .i_inc   (bus.dma_req_valid && !w_dma_acc),
        .i_clr   (w_dma_acc),
        .i_limit (STALL_CNT_W'(DMA_MAX_STALL)),
        .o_cnt   (w_stall_cnt),
        .o_force (w_force_dma)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state       <= ARB_RUN;
            r_rsp_pending <= 1'b0;
            r_rsp_owner   <= OWN_LSU;
        end else begin
            r_state       <= w_state_next;
            r_rsp_pending <= w_acc_read;
            if (w_acc_read) begin
                r_rsp_owner <= w_dma_acc ? OWN_DMA : OWN_LSU;
            end
        end
    end

    // Ack is raised as soon as HALTING sees the response pipe drained.
    always_comb begin
        w_state_next = r_state;
        w_halt_ack   = 1'b0;
        case (r_state)
            ARB_RUN: begin
                if (bus.arb_halt_req) w_state_next = ARB_HALTING;
            end
            ARB_HALTING: begin
                if (!bus.arb_halt_req) begin
                    w_state_next = ARB_RUN;
                end else if (!r_rsp_pending) begin
                    w_state_next = ARB_HALTED;
                    w_halt_ack   = 1'b1;
                end
            end
            ARB_HALTED: begin
                w_halt_ack = 1'b1;
                if (!bus.arb_halt_req) w_state_next = ARB_RUN;
            end
            default: w_state_next = ARB_RUN;
        endcase
    end

    a_aligned: assert property (@(posedge clk) disable iff (!rst_l)
        (w_lsu_acc || w_dma_acc) |-> ((w_sel_addr & ALIGN_MASK) == '0));
endmodule
